// File: rtl/mips_main_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_main_ctrl_fsm_if
// Description : Control/status bundle between the multicycle MIPS main
//               controller and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_main_ctrl_fsm_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       MemReq;
    logic       MemWrite;
    logic       IRWrite;
    logic       IorD;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       Illegal;
    logic [3:0] State;

    // Controller side
    modport master (
        input  Opcode, Zero, MemReady,
        output MemReq, MemWrite, IRWrite, IorD, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUop, PCSrc, PCEn, Illegal, State
    );

    // Datapath side
    modport slave (
        output Opcode, Zero, MemReady,
        input  MemReq, MemWrite, IRWrite, IorD, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUop, PCSrc, PCEn, Illegal, State
    );
endinterface
`default_nettype wire

// File: rtl/mips_main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mips_main_ctrl_fsm
// Description : Multicycle MIPS main control unit (Moore FSM) with MemReady
//               stalls. Optional bne support under macro MIPS_CTRL_BNE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_main_ctrl_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    mips_main_ctrl_fsm_if.master    bus
);

    localparam logic [3:0] c_FETCH   = 4'd0;
    localparam logic [3:0] c_DECODE  = 4'd1;
    localparam logic [3:0] c_MEMADR  = 4'd2;
    localparam logic [3:0] c_MEMRD   = 4'd3;
    localparam logic [3:0] c_MEMWB   = 4'd4;
    localparam logic [3:0] c_MEMWR   = 4'd5;
    localparam logic [3:0] c_EXECUTE = 4'd6;
    localparam logic [3:0] c_ALUWB   = 4'd7;
    localparam logic [3:0] c_BEQ     = 4'd8;
    localparam logic [3:0] c_ADDIEX  = 4'd9;
    localparam logic [3:0] c_ADDIWB  = 4'd10;
    localparam logic [3:0] c_JUMP    = 4'd11;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [3:0] c_BNE     = 4'd12;
    localparam logic [5:0] c_OP_BNE  = 6'b000101;
`endif

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_illegal;

    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_iord;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_branch_ne;
    logic       w_fetch_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = c_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            c_FETCH:   w_next = bus.MemReady ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (bus.Opcode)
                    c_OP_LW,
                    c_OP_SW:    w_next = c_MEMADR;
                    c_OP_RTYPE: w_next = c_EXECUTE;
                    c_OP_BEQ:   w_next = c_BEQ;
                    c_OP_ADDI:  w_next = c_ADDIEX;
                    c_OP_J:     w_next = c_JUMP;
`ifdef MIPS_CTRL_BNE_EN
                    c_OP_BNE:   w_next = c_BNE;
`endif
                    default: begin
                        w_next    = c_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            c_MEMADR:  w_next = (bus.Opcode == c_OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD:   w_next = bus.MemReady ? c_MEMWB : c_MEMRD;
            c_MEMWB:   w_next = c_FETCH;
            c_MEMWR:   w_next = bus.MemReady ? c_FETCH : c_MEMWR;
            c_EXECUTE: w_next = c_ALUWB;
            c_ALUWB:   w_next = c_FETCH;
            c_ADDIEX:  w_next = c_ADDIWB;
            c_ADDIWB:  w_next = c_FETCH;
            default:   w_next = c_FETCH;
        endcase
    end

    // Moore outputs; only the fetch handshake outputs look at MemReady.
    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_pc_src     = 2'b00;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        w_fetch_done = 1'b0;
        case (r_state)
            c_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b01;
                w_ir_write   = bus.MemReady;
                w_fetch_done = bus.MemReady;
            end
            c_DECODE: begin
                w_alu_src_b = 2'b11;
            end
            c_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            c_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            c_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            c_MEMWR: begin
                w_mem_req   = 1'b1;
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            c_EXECUTE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            c_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            c_BEQ: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b01;
                w_pc_src    = 2'b01;
                w_branch    = 1'b1;
            end
            c_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            c_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            c_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            c_BNE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b01;
                w_pc_src    = 2'b01;
                w_branch_ne = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.MemReq   = w_mem_req;
    assign bus.MemWrite = w_mem_write;
    assign bus.IRWrite  = w_ir_write;
    assign bus.IorD     = w_iord;
    assign bus.RegDst   = w_reg_dst;
    assign bus.MemtoReg = w_mem_to_reg;
    assign bus.RegWrite = w_reg_write;
    assign bus.ALUSrcA  = w_alu_src_a;
    assign bus.ALUSrcB  = w_alu_src_b;
    assign bus.ALUop    = w_alu_op;
    assign bus.PCSrc    = w_pc_src;
    assign bus.PCEn     = w_fetch_done | w_pc_write
                        | (w_branch & bus.Zero) | (w_branch_ne & ~bus.Zero);
    assign bus.Illegal  = w_illegal;
    assign bus.State    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_main_ctrl_fsm
// Description : Directed scoreboard bench for mips_main_ctrl_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_main_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       memreq;
        logic       memwrite;
        logic       irwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal;
    } exp_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    mips_main_ctrl_fsm_if bus ();

    mips_main_ctrl_fsm #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ)
          || (op == OP_ADDI) || (op == OP_J);
`ifdef MIPS_CTRL_BNE_EN
        ok = ok || (op == OP_BNE);
`endif
        return ok;
    endfunction

    // Reference output table, written from the state/output list.
    function automatic exp_t model(input logic [3:0] st, input logic mr,
                                   input logic z, input logic [5:0] op);
        exp_t e;
        e    = '0;
        e.st = st;
        case (st)
            4'd0:  begin e.memreq = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
            4'd1:  begin e.alusrcb = 2'b11; e.illegal = !supported(op); end
            4'd2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            4'd3:  begin e.memreq = 1; e.iord = 1; end
            4'd4:  begin e.regwrite = 1; e.memtoreg = 1; end
            4'd5:  begin e.memreq = 1; e.iord = 1; e.memwrite = 1; end
            4'd6:  begin e.alusrca = 1; e.aluop = 2'b10; end
            4'd7:  begin e.regwrite = 1; e.regdst = 1; end
            4'd8:  begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z; end
            4'd9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            4'd10: begin e.regwrite = 1; end
            4'd11: begin e.pcsrc = 2'b10; e.pcen = 1; end
`ifdef MIPS_CTRL_BNE_EN
            4'd12: begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = !z; end
`endif
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t g;
        g.st       = bus.State;
        g.memreq   = bus.MemReq;
        g.memwrite = bus.MemWrite;
        g.irwrite  = bus.IRWrite;
        g.iord     = bus.IorD;
        g.regdst   = bus.RegDst;
        g.memtoreg = bus.MemtoReg;
        g.regwrite = bus.RegWrite;
        g.alusrca  = bus.ALUSrcA;
        g.alusrcb  = bus.ALUSrcB;
        g.aluop    = bus.ALUop;
        g.pcsrc    = bus.PCSrc;
        g.pcen     = bus.PCEn;
        g.illegal  = bus.Illegal;
        return g;
    endfunction

    // Drive one cycle of inputs on the falling edge, queue the expectation,
    // then pop and compare once the combinational outputs have settled.
    task automatic step(input string tag, input logic [3:0] st, input logic mr,
                        input logic z, input logic [5:0] op, input logic rn);
        exp_t got;
        exp_t exp_v;
        @(negedge clk);
        rst_n        = rn;
        bus.MemReady = mr;
        bus.Zero     = z;
        bus.Opcode   = op;
        sb.push_back(model(st, mr, z, op));
        #1;
        got   = observe();
        exp_v = sb.pop_front();
        total++;
        assert (got === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp_v);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic req);
        total++;
        assert (obs === req)
        else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, req);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        bus.MemReady = 1'b0;
        bus.Zero     = 1'b0;
        bus.Opcode   = OP_R;
        repeat (2) @(posedge clk);

        step("reset_fetch", 4'd0, 1'b0, 1'b0, OP_LW, 1'b1);

        // lw, MemReady tied high: 0,1,2,3,4,0
        step("lw_fetch",  4'd0, 1'b1, 1'b0, OP_LW, 1'b1);
        step("lw_decode", 4'd1, 1'b1, 1'b0, OP_LW, 1'b1);
        step("lw_memadr", 4'd2, 1'b1, 1'b0, OP_LW, 1'b1);
        step("lw_memrd",  4'd3, 1'b1, 1'b0, OP_LW, 1'b1);
        step("lw_memwb",  4'd4, 1'b1, 1'b0, OP_LW, 1'b1);

        // R-type with MemReady low outside fetch (must be ignored)
        step("r_fetch",   4'd0, 1'b1, 1'b0, OP_R, 1'b1);
        step("r_decode",  4'd1, 1'b0, 1'b0, OP_R, 1'b1);
        step("r_execute", 4'd6, 1'b0, 1'b0, OP_R, 1'b1);
        step("r_aluwb",   4'd7, 1'b0, 1'b0, OP_R, 1'b1);

        // beq taken, then not taken
        step("beq1_fetch",  4'd0, 1'b1, 1'b1, OP_BEQ, 1'b1);
        step("beq1_decode", 4'd1, 1'b1, 1'b1, OP_BEQ, 1'b1);
        step("beq1_taken",  4'd8, 1'b1, 1'b1, OP_BEQ, 1'b1);
        check_bit("beq1_pcen", bus.PCEn, 1'b1);
        step("beq0_fetch",  4'd0, 1'b1, 1'b0, OP_BEQ, 1'b1);
        step("beq0_decode", 4'd1, 1'b1, 1'b0, OP_BEQ, 1'b1);
        step("beq0_nt",     4'd8, 1'b1, 1'b0, OP_BEQ, 1'b1);
        check_bit("beq0_pcen", bus.PCEn, 1'b0);

        // addi and jump
        step("addi_fetch",  4'd0,  1'b1, 1'b0, OP_ADDI, 1'b1);
        step("addi_decode", 4'd1,  1'b1, 1'b0, OP_ADDI, 1'b1);
        step("addi_ex",     4'd9,  1'b1, 1'b0, OP_ADDI, 1'b1);
        step("addi_wb",     4'd10, 1'b1, 1'b0, OP_ADDI, 1'b1);
        step("j_fetch",     4'd0,  1'b1, 1'b0, OP_J, 1'b1);
        step("j_decode",    4'd1,  1'b1, 1'b0, OP_J, 1'b1);
        step("j_jump",      4'd11, 1'b1, 1'b0, OP_J, 1'b1);

        // sw with 3 stall cycles in MEMWR
        step("sw_fetch",  4'd0, 1'b1, 1'b0, OP_SW, 1'b1);
        step("sw_decode", 4'd1, 1'b1, 1'b0, OP_SW, 1'b1);
        step("sw_memadr", 4'd2, 1'b1, 1'b0, OP_SW, 1'b1);
        step("sw_wr0",    4'd5, 1'b0, 1'b0, OP_SW, 1'b1);
        step("sw_wr1",    4'd5, 1'b0, 1'b0, OP_SW, 1'b1);
        step("sw_wr2",    4'd5, 1'b0, 1'b0, OP_SW, 1'b1);
        step("sw_wr3",    4'd5, 1'b1, 1'b0, OP_SW, 1'b1);

        // fetch stall, then an illegal opcode
        step("fst_0",      4'd0, 1'b0, 1'b0, OP_BAD, 1'b1);
        step("fst_1",      4'd0, 1'b0, 1'b0, OP_BAD, 1'b1);
        step("fst_go",     4'd0, 1'b1, 1'b0, OP_BAD, 1'b1);
        step("ill_decode", 4'd1, 1'b1, 1'b0, OP_BAD, 1'b1);
        check_bit("ill_pulse", bus.Illegal, 1'b1);

        // opcode 000101
        step("bne_fetch",  4'd0, 1'b1, 1'b0, OP_BNE, 1'b1);
        step("bne_decode", 4'd1, 1'b1, 1'b0, OP_BNE, 1'b1);
`ifdef MIPS_CTRL_BNE_EN
        step("bne_nz",     4'd12, 1'b1, 1'b0, OP_BNE, 1'b1);
        step("bne2_fetch", 4'd0,  1'b1, 1'b1, OP_BNE, 1'b1);
        step("bne2_dec",   4'd1,  1'b1, 1'b1, OP_BNE, 1'b1);
        step("bne_z",      4'd12, 1'b1, 1'b1, OP_BNE, 1'b1);
`endif

        // reset asserted for two cycles while stalled in MEMWR
        step("rs_fetch",  4'd0, 1'b1, 1'b0, OP_SW, 1'b1);
        step("rs_decode", 4'd1, 1'b1, 1'b0, OP_SW, 1'b1);
        step("rs_memadr", 4'd2, 1'b1, 1'b0, OP_SW, 1'b1);
        step("rs_wr",     4'd5, 1'b0, 1'b0, OP_SW, 1'b1);
        step("rs_hold0",  4'd5, 1'b0, 1'b0, OP_SW, 1'b0);
        step("rs_hold1",  4'd0, 1'b0, 1'b0, OP_SW, 1'b0);
        step("rs_out",    4'd0, 1'b0, 1'b0, OP_SW, 1'b1);
        check_bit("rs_memwrite", bus.MemWrite, 1'b0);
        step("rs_go",     4'd0, 1'b1, 1'b0, OP_SW, 1'b1);
        step("rs_decode2",4'd1, 1'b1, 1'b0, OP_SW, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mips_main_ctrl_fsm.md
Name: mips_main_ctrl_fsm

Overview:
Multicycle MIPS main control unit, directly upstream of the ALU decoder. It decodes Opcode into a Moore state sequence and drives the datapath enables, muxes and the 2-bit ALUop consumed by the ALU decoder. It combines Branch with the ALU Zero flag to form the PC enable. A MemReady handshake lets fetch and data-memory states stall on slow memory.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); must not be changed from 0.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
Opcode  input  6  instruction bits [31:26], valid from DECODE onward (IR held)
Zero  input  1  ALU zero flag, sampled combinationally in branch states
MemReady  input  1  memory done; completes the current access this cycle
MemReq  output  1  memory access request
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
IorD  output  1  address mux: 0=PC, 1=ALUOut
RegDst  output  1  0=rt, 1=rd
MemtoReg  output  1  0=ALUOut, 1=Data
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
ALUop  output  2  to ALU decoder: 00 add, 01 sub, 10 use Funct
PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
PCEn  output  1  PC register enable
Illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode
State  output  4  current state, for debug/verification

Behaviour:
- State register is 4 bits, updated on the rising edge of clk. When rst_n is low at the edge, the next state is FETCH (0), whatever the current state; this holds mid-instruction and mid-stall.
- Outputs are decoded from state only, except for the MemReady gating listed below. Any output not listed for a state is 0.
- Reset values, i.e. outputs in FETCH: MemReq=1, ALUSrcB=01, IRWrite=MemReady, PCEn=MemReady. Every other output is 0, and State=0.
- State encodings and outputs:
  - FETCH 0: as above.
  - DECODE 1: ALUSrcB=11, ALUop=00.
  - MEMADR 2: ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - MEMRD 3: MemReq=1, IorD=1.
  - MEMWB 4: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR 5: MemReq=1, IorD=1, MemWrite=1.
  - EXECUTE 6: ALUSrcA=1, ALUSrcB=00, ALUop=10.
  - ALUWB 7: RegWrite=1, RegDst=1.
  - BEQ 8: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSrc=01, Branch=1 (internal).
  - ADDIEX 9: ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - ADDIWB 10: RegWrite=1, RegDst=0.
  - JUMP 11: PCSrc=10, PCWrite=1 (internal).
  - BNE 12: see Optional Feature.
- PCEn = (FETCH & MemReady) | PCWrite | (Branch & Zero) | (BranchNe & ~Zero). It is combinational, with no added latency.
- Transitions:
  - FETCH to DECODE when MemReady=1; otherwise hold FETCH.
  - DECODE, by Opcode:
    - 100011 or 101011 to MEMADR
    - 000000 to EXECUTE
    - 000100 to BEQ
    - 001000 to ADDIEX
    - 000010 to JUMP
    - any other opcode to FETCH, with Illegal=1 for that cycle
  - MEMADR: to MEMRD if Opcode=100011, else to MEMWR.
  - MEMRD to MEMWB when MemReady=1, else hold.
  - MEMWR to FETCH when MemReady=1, else hold. MemWrite stays high for the whole hold.
  - EXECUTE to ALUWB, then FETCH.
  - ADDIEX to ADDIWB, then FETCH.
  - BEQ to FETCH. JUMP to FETCH.
- Unused encodings 13–15 (and 12 when BNE is disabled): all outputs 0, next state FETCH.
- Instruction latency with MemReady tied to 1:
  - lw 5 cycles
  - sw, R-type and addi 4 cycles
  - beq and j 3 cycles
  - illegal opcode 2 cycles
- MemReady is ignored in every state except FETCH, MEMRD and MEMWR.

Optional Feature:
- Macro MIPS_CTRL_BNE_EN.
- Defined: in DECODE, Opcode 000101 goes to BNE (12). BNE drives ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSrc=01 and BranchNe=1, so PCEn=~Zero. Next state is FETCH.
- Undefined: 000101 is illegal (Illegal pulse, return to FETCH), BranchNe is tied to 0, and state 12 behaves as an unused encoding.

Test Plan:
- Reset: rst_n=0 for 2 cycles while in MEMWR, then release -> State=0, MemWrite=0, MemReq=1, ALUSrcB=01; with MemReady=0, IRWrite=0 and PCEn=0.
- lw with MemReady=1 -> State 0,1,2,3,4,0. ALUop=00 in states 1 and 2. RegWrite=1 and MemtoReg=1 only in state 4.
- R-type (000000) -> State 0,1,6,7,0. ALUop=10 in state 6. RegWrite=1 and RegDst=1 in state 7.
- beq: Zero=1 -> PCEn=1, PCSrc=01, ALUop=01 in state 8. Repeat with Zero=0 -> PCEn=0.
- sw with MemReady held 0 for 3 cycles in MEMWR -> State stays 5 for 4 cycles, MemWrite=1 throughout, then returns to 0. Fetch stall: MemReady=0 for 2 cycles -> State stays 0 and PCEn=0 until MemReady=1.
- Opcode 000101 -> without macro: Illegal=1 in DECODE, State 0,1,0. With MIPS_CTRL_BNE_EN: State 0,1,12,0, and PCEn=1 in state 12 only when Zero=0.
